// File: rtl/uint16_calc_sequencer.sv
// Sequencer for a combinational 16-bit calculator: accepts one command, holds the
// calculator inputs for SETTLE_CYCLES, captures the result and hands it back.
`timescale 1ns/1ps

module uint16_calc_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic                     cmd_chain,
  input  logic [15:0]              cmd_a,
  input  logic [15:0]              cmd_b,
  input  logic                     clear,
  output logic [15:0]              calc_a,
  output logic [15:0]              calc_b,
  output logic                     calc_add,
  output logic                     calc_subtract,
  output logic                     calc_divide,
  output logic                     calc_multiply,
  input  logic [15:0]              calc_result,
  input  logic                     calc_invalid,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_result,
  output logic                     rsp_error,
  output logic [15:0]              acc,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t                   r_state;
  logic [15:0]              r_a;
  logic [15:0]              r_b;
  logic [3:0]               r_cnt;
  logic [3:0]               r_strobe;
  logic                     r_cmd_ready;
  logic                     r_rsp_valid;
  logic                     r_rsp_error;
  logic [15:0]              r_rsp_result;
  logic [15:0]              r_acc;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  logic [15:0] w_a_sel;
  logic [3:0]  w_strobe_dec;
  logic        w_err_sat;

  // Chained commands take the accumulator as it is before any same-cycle clear.
  assign w_a_sel   = cmd_chain ? r_acc : cmd_a;
  assign w_err_sat = &r_err_count;

  // Strobe vector ordering: {add, subtract, divide, multiply}.
  always_comb begin
    w_strobe_dec = 4'b0000;
    case (cmd_op)
      2'b00:   w_strobe_dec = 4'b1000;
      2'b01:   w_strobe_dec = 4'b0100;
      2'b10:   w_strobe_dec = 4'b0010;
      default: w_strobe_dec = 4'b0001;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_strobe     <= '0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_error  <= 1'b0;
      r_rsp_result <= '0;
      r_acc        <= '0;
      r_err_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_a         <= w_a_sel;
            r_b         <= cmd_b;
            r_strobe    <= w_strobe_dec;
            r_cnt       <= SETTLE_LOAD;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == 4'd0) begin
            // Operands stay put after capture; only the strobes drop.
            r_strobe     <= '0;
            r_rsp_error  <= calc_invalid;
            r_rsp_result <= calc_invalid ? 16'd0 : calc_result;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
            if (!calc_invalid) begin
              r_acc <= calc_result;
            end else if (!w_err_sat) begin
              r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_strobe    <= '0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase

      // Clear overrides any capture-time bookkeeping update in the same cycle.
      if (clear) begin
        r_acc       <= '0;
        r_err_count <= '0;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign calc_a        = r_a;
  assign calc_b        = r_b;
  assign calc_add      = r_strobe[3];
  assign calc_subtract = r_strobe[2];
  assign calc_divide   = r_strobe[1];
  assign calc_multiply = r_strobe[0];
  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_error     = r_rsp_error;
  assign acc           = r_acc;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_uint16_calc_sequencer.sv
// Scoreboard bench for uint16_calc_sequencer with a behavioural calculator attached.
`timescale 1ns/1ps

module tb_uint16_calc_sequencer;

  localparam int SETTLE = 2;
  localparam int ERR_W  = 8;
  localparam int EC_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic             cmd_chain = 1'b0;
  logic [15:0]      cmd_a = 16'd0;
  logic [15:0]      cmd_b = 16'd0;
  logic             clear = 1'b0;
  logic [15:0]      calc_a, calc_b;
  logic             calc_add, calc_subtract, calc_divide, calc_multiply;
  logic [15:0]      calc_result;
  logic             calc_invalid;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [15:0]      rsp_result;
  logic             rsp_error;
  logic [15:0]      acc;
  logic [ERR_W-1:0] err_count;

  always #5 clk = ~clk;

  uint16_calc_sequencer #(.SETTLE_CYCLES(SETTLE), .ERR_CNT_WIDTH(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .clear(clear),
    .calc_a(calc_a), .calc_b(calc_b), .calc_add(calc_add), .calc_subtract(calc_subtract),
    .calc_divide(calc_divide), .calc_multiply(calc_multiply),
    .calc_result(calc_result), .calc_invalid(calc_invalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .acc(acc), .err_count(err_count)
  );

  // Attached calculator: invalid unless exactly one operation is selected, or on x/0.
  always_comb begin
    calc_result  = 16'hBAD0;
    calc_invalid = 1'b1;
    case ({calc_add, calc_subtract, calc_divide, calc_multiply})
      4'b1000: begin calc_result = calc_a + calc_b; calc_invalid = 1'b0; end
      4'b0100: begin calc_result = calc_a - calc_b; calc_invalid = 1'b0; end
      4'b0010: if (calc_b != 16'd0) begin calc_result = calc_a / calc_b; calc_invalid = 1'b0; end
      4'b0001: begin calc_result = calc_a * calc_b; calc_invalid = 1'b0; end
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [15:0] acc;
    logic [7:0]  ec;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] m_acc = 16'd0;
  int          m_ec  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 16-bit wrapping arithmetic, accumulator and saturating error tally.
  task automatic model_step(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            output exp_t e);
    int unsigned r = 0;
    bit bad = 1'b0;
    case (op)
      2'd0: r = 32'(a) + 32'(b);
      2'd1: r = 32'(a) - 32'(b);
      2'd2: if (b == 16'd0) bad = 1'b1; else r = 32'(a / b);
      default: r = 32'(a) * 32'(b);
    endcase
    e.res = bad ? 16'd0 : r[15:0];
    e.err = bad;
    if (!bad) m_acc = r[15:0];
    else if (m_ec < EC_MAX) m_ec++;
    e.acc = m_acc;
    e.ec  = 8'(m_ec);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_calc_a", 32'(calc_a), 32'd0);
    check("rst_calc_b", 32'(calc_b), 32'd0);
    check("rst_strobes", 32'({calc_add, calc_subtract, calc_divide, calc_multiply}), 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_cmd_ready: got 0 expected 1 within 100 cycles");
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic chain, input logic [15:0] a,
                        input logic [15:0] b, input int hold);
    exp_t e;
    logic [15:0] a_eff;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_chain = chain; cmd_a = a; cmd_b = b;
    a_eff = chain ? m_acc : a;
    model_step(op, a_eff, b, e);
    sb_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_chain = 1'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
    for (int c = 1; c <= SETTLE; c++) begin
      @(negedge clk);
      check("drive_strobes", 32'({calc_add, calc_subtract, calc_divide, calc_multiply}),
            32'(4'b1000 >> op));
      check("drive_calc_a", 32'(calc_a), 32'(a_eff));
      check("drive_calc_b", 32'(calc_b), 32'(b));
      check("drive_rsp_valid", 32'(rsp_valid), 32'd0);
      check("drive_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    check("resp_latency_valid", 32'(rsp_valid), 32'd1);
    check("resp_strobes_off", 32'({calc_add, calc_subtract, calc_divide, calc_multiply}), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      cmd_valid = ~cmd_valid;
      @(negedge clk);
      check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_acc = 16'd0;
    m_ec  = 0;
    @(negedge clk);
    check("clear_acc", 32'(acc), 32'd0);
    check("clear_err_count", 32'(err_count), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each response handshake, checks hold-stability.
  initial begin
    exp_t        e;
    bit          held = 1'b0;
    logic [15:0] held_res = 16'd0;
    logic        held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !rsp_valid) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("rsp_stable_result", 32'(rsp_result), 32'(held_res));
          check("rsp_stable_error", 32'(rsp_error), 32'(held_err));
        end
        if (rsp_ready) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got result %0h with empty scoreboard", rsp_result);
          end else begin
            e = sb_q.pop_front();
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("rsp_error", 32'(rsp_error), 32'(e.err));
            check("acc", 32'(acc), 32'(e.acc));
            check("err_count", 32'(err_count), 32'(e.ec));
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_res = rsp_result;
          held_err = rsp_error;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    do_cmd(2'd0, 1'b0, 16'd1000, 16'd234, 0);
    do_cmd(2'd1, 1'b1, 16'hDEAD, 16'd34, 0);
    do_cmd(2'd3, 1'b1, 16'hDEAD, 16'd3, 0);
    do_cmd(2'd2, 1'b0, 16'd7, 16'd0, 0);
    do_clear();
    do_cmd(2'd0, 1'b0, 16'd42, 16'd58, 5);
    do_cmd(2'd0, 1'b0, 16'hFFFF, 16'd2, 0);
    do_cmd(2'd3, 1'b0, 16'd300, 16'd300, 1);

    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom), 1'($urandom), 16'($urandom),
             ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom), int'($urandom_range(3)));
    end

    // Reset during DRIVE: outputs snap to reset values and the command vanishes.
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_chain = 1'b0; cmd_a = 16'd5; cmd_b = 16'd6;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    m_acc = 16'd0;
    m_ec  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
    end

    for (int i = 0; i < 260; i++) begin
      do_cmd(2'd2, 1'b0, 16'($urandom), 16'd0, 0);
    end
    check("err_count_saturated", 32'(err_count), 32'(EC_MAX));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
